// File: rtl/regfile_pkg.sv
// Shared constants and the write-entry bundle for the
// register-file write queue.
package regfile_pkg;

  localparam int         NUM_REGS = 32;
  localparam logic [4:0] ZERO_REG = 5'd31;
  localparam int         WIDTH    = 64;

  typedef struct packed {
    logic [4:0]       rd;
    logic [WIDTH-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/wq_fifo.sv
// Generic circular buffer: push/pop, count, full/empty, head read.
// Ports: clk, reset, push_i/data_i, pop_i, head_o, entries_o, head_ptr_o,
//        full_o, empty_o, count_o.
module wq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int EW    = 69,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  logic [EW-1:0]       data_i,
  input  logic                pop_i,
  output logic [EW-1:0]       head_o,
  output logic [DEPTH*EW-1:0] entries_o,
  output logic [AW-1:0]       head_ptr_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CW-1:0]       count_o
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;

  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: slots are qualified by count.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= data_i;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign entries_o[i*EW +: EW] = mem_q[i];
  end

  assign head_o     = mem_q[head_q];
  assign head_ptr_o = head_q;
  assign count_o    = count_q;

endmodule

// File: rtl/regfile_write_queue.sv
// In-order write queue in front of the register file with bypass lookup.
// Ports: ALU/MEM request handshakes, register-file write port, two
//        bypass lookups (q_rN -> hitN/bypN), empty and count status.
module regfile_write_queue #(
  parameter  int         DEPTH    = 4,
  parameter  int         WIDTH    = regfile_pkg::WIDTH,
  parameter  logic [4:0] ZERO_REG = regfile_pkg::ZERO_REG,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         CW       = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [WIDTH-1:0] mem_data,
  output logic             mem_ready,
  output logic [4:0]       r_write,
  output logic [WIDTH-1:0] data_in,
  output logic             write_E,
  input  logic [4:0]       q_r1,
  input  logic [4:0]       q_r2,
  output logic             hit1,
  output logic             hit2,
  output logic [WIDTH-1:0] byp1,
  output logic [WIDTH-1:0] byp2,
  output logic             empty,
  output logic [CW-1:0]    count
);

  typedef struct packed {
    logic [4:0]       rd;
    logic [WIDTH-1:0] data;
  } ent_t;

  localparam int EW = $bits(ent_t);

  logic [DEPTH*EW-1:0] flat;
  logic [AW-1:0]       hptr;
  logic [EW-1:0]       head_raw;
  ent_t                head;
  ent_t                ent [DEPTH];
  ent_t                push_ent;
  logic                full, alu_fire, mem_fire, push;

  assign alu_ready = !full;
  assign mem_ready = !full && !alu_valid;
  assign alu_fire  = alu_valid && alu_ready;
  assign mem_fire  = mem_valid && mem_ready;

  // ZERO_REG requests complete the handshake but never occupy a slot.
  assign push = (alu_fire && alu_rd != ZERO_REG) ||
                (mem_fire && mem_rd != ZERO_REG);

  assign push_ent = alu_fire ? ent_t'{alu_rd, alu_data}
                             : ent_t'{mem_rd, mem_data};

  wq_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .data_i     (push_ent),
    .pop_i      (1'b1),
    .head_o     (head_raw),
    .entries_o  (flat),
    .head_ptr_o (hptr),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count)
  );

  assign head    = ent_t'(head_raw);
  assign write_E = !empty;
  assign r_write = empty ? '0 : head.rd;
  assign data_in = empty ? '0 : head.data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent[i] = ent_t'(flat[i*EW +: EW]);
  end

  // Walk oldest to newest so the newest match overwrites older ones.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    byp1 = '0;
    byp2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (q_r1 != ZERO_REG && ent[hptr + AW'(i)].rd == q_r1) begin
          hit1 = 1'b1;
          byp1 = ent[hptr + AW'(i)].data;
        end
        if (q_r2 != ZERO_REG && ent[hptr + AW'(i)].rd == q_r2) begin
          hit2 = 1'b1;
          byp2 = ent[hptr + AW'(i)].data;
        end
      end
    end
  end

endmodule
